noc_link_tx: RTL and testbench

- Read-side companion of the router input buffer.
- Drains flits from an input_buffer and drives them onto the inter-router link toward the next router's input buffer.
- Flow control is credit-based. The credit count tracks free slots in the downstream buffer, so the block never overflows it.
- One instance per router output port.

---
 rtl/noc_pkg.sv | 14 +
 rtl/noc_credit_counter.sv | 45 ++++
 rtl/noc_link_tx.sv | 93 +++++++++
 tb/tb_noc_link_tx.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC link types: flit width, downstream buffer depth and the link TX FSM states.
// No logic here, so no latency or flow control of its own.
package noc_pkg;
  localparam int FLIT_W       = 16;
  localparam int LINK_CREDITS = 8;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    INIT,
    SEND,
    STALL
  } tx_state_e;
endpackage

// File: rtl/noc_credit_counter.sv
// Up/down credit counter that saturates at MAX and flags a sticky error on overflow.
// The count updates one cycle after inc_i/dec_i; there is no flow control, inc_i and dec_i are plain per-cycle strobes.
module noc_credit_counter
  import noc_pkg::*;
#(
  parameter int MAX = LINK_CREDITS,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         err_o
);
  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;
  logic         err_q, err_d;

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (inc_i && !dec_i) begin
      // A credit beyond MAX means the downstream side returned more than it was given.
      if (cnt_q == MaxVal) err_d = 1'b1;
      else                 cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= MaxVal;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = cnt_q;
  assign err_o = err_q;
endmodule

// File: rtl/noc_link_tx.sv
// Drains an input buffer onto a credit-flow-controlled inter-router link; 2 cycles from buf_read_o to link_valid_o.
// Reads stop when no credit is available (counting a credit arriving this cycle) or the buffer is empty.
module noc_link_tx
  import noc_pkg::*;
#(
  parameter int DATA_W  = FLIT_W,
  parameter int CREDITS = LINK_CREDITS,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              buf_empty_i,
  input  logic              buf_valid_i,
  input  logic [DATA_W-1:0] buf_data_i,
  output logic              buf_read_o,
  output logic              link_valid_o,
  output logic [DATA_W-1:0] link_data_o,
  input  logic              link_credit_i,
  output logic [CNT_W-1:0]  credit_cnt_o,
  output logic [15:0]       tx_count_o,
  output logic              err_o
);
  tx_state_e         state_q, state_d;
  logic              rd_inflight_q, rd_inflight_d;
  logic              link_valid_q, link_valid_d;
  logic [DATA_W-1:0] link_data_q, link_data_d;
  logic [15:0]       tx_count_q, tx_count_d;
  logic              proto_err_q, proto_err_d;

  logic [CNT_W-1:0]  credit_cnt;
  logic              credit_err;
  logic              have_credit;
  logic              rd;
  logic              accept;

  // The arriving credit counts toward the issue decision, so STALL can read in the cycle it leaves.
  assign have_credit = (credit_cnt != '0) || link_credit_i;
  assign rd          = reset && (state_q != INIT) && !buf_empty_i && have_credit;
  // INIT is exactly the first cycle after reset, when a stale read response may still arrive.
  assign accept      = buf_valid_i && (state_q != INIT);

  noc_credit_counter #(
    .MAX (CREDITS),
    .W   (CNT_W)
  ) u_credit (
    .clk   (clk),
    .reset (reset),
    .inc_i (link_credit_i),
    .dec_i (rd),
    .cnt_o (credit_cnt),
    .err_o (credit_err)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    state_d = SEND;
      SEND:    if (rd && !link_credit_i && credit_cnt == CNT_W'(1)) state_d = STALL;
      STALL:   if (link_credit_i) state_d = SEND;
      default: state_d = INIT;
    endcase
    rd_inflight_d = rd;
    link_valid_d  = accept;
    link_data_d   = accept ? buf_data_i : link_data_q;
    tx_count_d    = tx_count_q + 16'(accept);
    proto_err_d   = proto_err_q | ((state_q != INIT) && (buf_valid_i != rd_inflight_q));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= INIT;
      rd_inflight_q <= 1'b0;
      link_valid_q  <= 1'b0;
      link_data_q   <= '0;
      tx_count_q    <= '0;
      proto_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_inflight_q <= rd_inflight_d;
      link_valid_q  <= link_valid_d;
      link_data_q   <= link_data_d;
      tx_count_q    <= tx_count_d;
      proto_err_q   <= proto_err_d;
    end
  end

  assign buf_read_o   = rd;
  assign link_valid_o = link_valid_q;
  assign link_data_o  = link_data_q;
  assign credit_cnt_o = credit_cnt;
  assign tx_count_o   = tx_count_q;
  assign err_o        = proto_err_q | credit_err;
endmodule

// File: tb/tb_noc_link_tx.sv
// Bench for noc_link_tx: models the upstream input buffer and scoreboards every flit that reaches the link.
module tb_noc_link_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        buf_empty_i = 1'b1;
  logic        buf_valid_i = 1'b0;
  logic [15:0] buf_data_i = 16'h0;
  logic        link_credit_i = 1'b0;
  logic        buf_read_o;
  logic        link_valid_o;
  logic [15:0] link_data_o;
  logic [3:0]  credit_cnt_o;
  logic [15:0] tx_count_o;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] up_q[$];
  logic [15:0] sb_q[$];

  noc_link_tx dut (
    .clk           (clk),
    .reset         (reset),
    .buf_empty_i   (buf_empty_i),
    .buf_valid_i   (buf_valid_i),
    .buf_data_i    (buf_data_i),
    .buf_read_o    (buf_read_o),
    .link_valid_o  (link_valid_o),
    .link_data_o   (link_data_o),
    .link_credit_i (link_credit_i),
    .credit_cnt_o  (credit_cnt_o),
    .tx_count_o    (tx_count_o),
    .err_o         (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  // One clock: sample the read strobe mid-cycle, then play the upstream buffer's response.
  task automatic cycle(output logic rd);
    logic [15:0] d;
    d = buf_data_i;
    @(negedge clk);
    rd = buf_read_o;
    if (rd && up_q.size() > 0) begin
      d = up_q.pop_front();
      sb_q.push_back(d);
    end
    @(posedge clk);
    #1;
    buf_valid_i   = rd;
    buf_data_i    = d;
    buf_empty_i   = (up_q.size() == 0);
    link_credit_i = 1'b0;
  endtask

  task automatic do_reset();
    logic rd;
    reset = 1'b0;
    link_credit_i = 1'b0;
    buf_valid_i = 1'b0;
    buf_empty_i = 1'b1;
    up_q.delete();
    sb_q.delete();
    cycle(rd);
    cycle(rd);
    reset = 1'b1;
    cycle(rd);
  endtask

  task automatic test_reset();
    logic rd;
    logic [15:0] exp;
    reset = 1'b0;
    buf_empty_i = 1'b1;
    up_q.delete();
    sb_q.delete();
    cycle(rd);
    cycle(rd);
    checks++; if (credit_cnt_o !== 4'd8) begin errors++; $display("FAIL reset_credit: got %0d want 8", credit_cnt_o); end
    checks++; if (link_valid_o !== 1'b0) begin errors++; $display("FAIL reset_link_valid: got %b want 0", link_valid_o); end
    checks++; if (tx_count_o !== 16'd0) begin errors++; $display("FAIL reset_tx_count: got %0d want 0", tx_count_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_o); end
    checks++; if (buf_read_o !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", buf_read_o); end
    up_q.push_back(16'h1234);
    buf_empty_i = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if (buf_read_o !== 1'b0) begin errors++; $display("FAIL init_no_read: got %b want 0", buf_read_o); end
    cycle(rd);
    #1;
    checks++; if (buf_read_o !== 1'b1) begin errors++; $display("FAIL send_read: got %b want 1", buf_read_o); end
    for (int c = 0; c < 4; c++) begin
      cycle(rd);
      if (link_valid_o === 1'b1) begin
        checks++;
        exp = 'x;
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        if (link_data_o !== exp) begin errors++; $display("FAIL reset_flit: got %h want %h", link_data_o, exp); end
      end
    end
    checks++; if (tx_count_o !== 16'd1) begin errors++; $display("FAIL reset_drain_tx: got %0d want 1", tx_count_o); end
  endtask

  task automatic test_single();
    logic rd;
    do_reset();
    up_q.push_back(16'h8000);
    buf_empty_i = 1'b0;
    cycle(rd);
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL single_read_T: got %b want 1", rd); end
    checks++; if (link_valid_o !== 1'b0) begin errors++; $display("FAIL single_valid_T1: got %b want 0", link_valid_o); end
    checks++; if (credit_cnt_o !== 4'd7) begin errors++; $display("FAIL single_credit_T1: got %0d want 7", credit_cnt_o); end
    cycle(rd);
    checks++; if (link_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid_T2: got %b want 1", link_valid_o); end
    checks++; if (link_data_o !== 16'h8000) begin errors++; $display("FAIL single_data_T2: got %h want 8000", link_data_o); end
    checks++; if (tx_count_o !== 16'd1) begin errors++; $display("FAIL single_tx: got %0d want 1", tx_count_o); end
    checks++; if (credit_cnt_o !== 4'd7) begin errors++; $display("FAIL single_credit_T2: got %0d want 7", credit_cnt_o); end
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    cycle(rd);
    checks++; if (link_valid_o !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b want 0", link_valid_o); end
    checks++; if (link_data_o !== 16'h8000) begin errors++; $display("FAIL single_hold: got %h want 8000", link_data_o); end
  endtask

  task automatic test_stall();
    logic rd;
    logic [15:0] exp;
    int nrd, first, last;
    do_reset();
    for (int i = 0; i < 10; i++) up_q.push_back(16'hA000 + 16'(i));
    buf_empty_i = 1'b0;
    nrd = 0; first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      cycle(rd);
      if (rd) begin
        nrd++;
        if (first < 0) first = c;
        last = c;
      end
      if (link_valid_o === 1'b1) begin
        checks++;
        exp = 'x;
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        if (link_data_o !== exp) begin errors++; $display("FAIL stall_flit: got %h want %h", link_data_o, exp); end
      end
    end
    checks++; if (nrd !== 8) begin errors++; $display("FAIL stall_reads: got %0d want 8", nrd); end
    checks++; if (last - first !== 7) begin errors++; $display("FAIL stall_b2b: span %0d want 7", last - first); end
    checks++; if (credit_cnt_o !== 4'd0) begin errors++; $display("FAIL stall_credit: got %0d want 0", credit_cnt_o); end
    #1;
    checks++; if (buf_read_o !== 1'b0) begin errors++; $display("FAIL stall_no_read: got %b want 0", buf_read_o); end
    link_credit_i = 1'b1;
    #1;
    checks++; if (buf_read_o !== 1'b1) begin errors++; $display("FAIL stall_credit_read: got %b want 1", buf_read_o); end
    cycle(rd);
    checks++; if (credit_cnt_o !== 4'd0) begin errors++; $display("FAIL stall_credit_after: got %0d want 0", credit_cnt_o); end
    for (int c = 0; c < 4; c++) begin
      cycle(rd);
      if (c == 0) begin
        checks++; if (rd !== 1'b0) begin errors++; $display("FAIL stall_single_extra: got %b want 0", rd); end
      end
      if (link_valid_o === 1'b1) begin
        checks++;
        exp = 'x;
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        if (link_data_o !== exp) begin errors++; $display("FAIL stall_flit: got %h want %h", link_data_o, exp); end
      end
    end
    checks++; if (tx_count_o !== 16'd9) begin errors++; $display("FAIL stall_tx: got %0d want 9", tx_count_o); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL stall_lost: got %0d pending want 0", sb_q.size()); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL stall_err: got %b want 0", err_o); end
  endtask

  task automatic test_stream();
    logic rd;
    logic [15:0] exp;
    int nrd;
    do_reset();
    for (int i = 0; i < 20; i++) up_q.push_back(16'hC000 + 16'(i));
    buf_empty_i = 1'b0;
    for (int c = 0; c < 15 + 5; c++) begin
      if (c >= 7 && c < 15) link_credit_i = 1'b1;
      cycle(rd);
      if (c == 6) begin
        checks++; if (credit_cnt_o !== 4'd1) begin errors++; $display("FAIL stream_credit_start: got %0d want 1", credit_cnt_o); end
        nrd = 0;
      end
      if (c >= 7 && c < 15) begin
        if (rd) nrd++;
        checks++; if (credit_cnt_o !== 4'd1) begin errors++; $display("FAIL stream_credit_c%0d: got %0d want 1", c, credit_cnt_o); end
      end
      if (link_valid_o === 1'b1) begin
        checks++;
        exp = 'x;
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        if (link_data_o !== exp) begin errors++; $display("FAIL stream_flit: got %h want %h", link_data_o, exp); end
      end
    end
    checks++; if (nrd !== 8) begin errors++; $display("FAIL stream_reads: got %0d want 8", nrd); end
    checks++; if (credit_cnt_o !== 4'd0) begin errors++; $display("FAIL stream_credit_end: got %0d want 0", credit_cnt_o); end
    checks++; if (tx_count_o !== 16'd16) begin errors++; $display("FAIL stream_tx: got %0d want 16", tx_count_o); end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL stream_lost: got %0d pending want 0", sb_q.size()); end
  endtask

  task automatic test_err();
    logic rd;
    do_reset();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear0: got %b want 0", err_o); end
    link_credit_i = 1'b1;
    cycle(rd);
    checks++; if (credit_cnt_o !== 4'd8) begin errors++; $display("FAIL err_sat_credit: got %0d want 8", credit_cnt_o); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_overflow: got %b want 1", err_o); end
    for (int c = 0; c < 3; c++) cycle(rd);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_overflow_sticky: got %b want 1", err_o); end
    do_reset();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_clear1: got %b want 0", err_o); end
    buf_valid_i = 1'b1;
    buf_data_i = 16'h5555;
    cycle(rd);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_spurious: got %b want 1", err_o); end
    checks++; if (link_valid_o !== 1'b1) begin errors++; $display("FAIL err_spurious_fwd: got %b want 1", link_valid_o); end
    checks++; if (link_data_o !== 16'h5555) begin errors++; $display("FAIL err_spurious_data: got %h want 5555", link_data_o); end
    cycle(rd);
    cycle(rd);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_spurious_sticky: got %b want 1", err_o); end
    do_reset();
    up_q.push_back(16'h0F0F);
    buf_empty_i = 1'b0;
    cycle(rd);
    buf_valid_i = 1'b0;
    sb_q.delete();
    cycle(rd);
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_missing_valid: got %b want 1", err_o); end
    checks++; if (link_valid_o !== 1'b0) begin errors++; $display("FAIL err_missing_fwd: got %b want 0", link_valid_o); end
  endtask

  task automatic test_reset_mid();
    logic rd;
    logic [15:0] exp;
    int nfl;
    do_reset();
    for (int i = 0; i < 3; i++) up_q.push_back(16'hB000 + 16'(i));
    buf_empty_i = 1'b0;
    cycle(rd);
    checks++; if (rd !== 1'b1) begin errors++; $display("FAIL mid_read: got %b want 1", rd); end
    reset = 1'b0;
    cycle(rd);
    checks++; if (link_valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", link_valid_o); end
    checks++; if (credit_cnt_o !== 4'd8) begin errors++; $display("FAIL mid_credit: got %0d want 8", credit_cnt_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mid_err: got %b want 0", err_o); end
    sb_q.delete();
    reset = 1'b1;
    buf_valid_i = 1'b1;
    buf_data_i = 16'hDEAD;
    cycle(rd);
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL mid_init_read: got %b want 0", rd); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mid_stale_err: got %b want 0", err_o); end
    checks++; if (link_valid_o !== 1'b0) begin errors++; $display("FAIL mid_stale_fwd: got %b want 0", link_valid_o); end
    nfl = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(rd);
      if (link_valid_o === 1'b1) begin
        checks++;
        nfl++;
        exp = 'x;
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        if (link_data_o !== exp) begin errors++; $display("FAIL mid_flit: got %h want %h", link_data_o, exp); end
      end
    end
    checks++; if (nfl !== 2) begin errors++; $display("FAIL mid_flits: got %0d want 2", nfl); end
    checks++; if (tx_count_o !== 16'd2) begin errors++; $display("FAIL mid_tx: got %0d want 2", tx_count_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL mid_err_end: got %b want 0", err_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_stream();
    test_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
